dsp_seq_ctrl: RTL and testbench
===============================

Name: dsp_seq_ctrl

Overview:
Sequencer for the BRAM0 -> DSP -> BRAM1 datapath. On a start handshake it issues a burst of consecutive BRAM0 read addresses. It also generates the matching BRAM1 write enable and address, delayed by the fixed datapath latency. It drains the pipeline, then signals completion; it sits between the top-level control and the memory/DSP datapath.

Parameters:
ADDR_WIDTH, 5, BRAM address width (depth 2^ADDR_WIDTH)
LAT, 4, cycles from read issue to DSP result valid at BRAM1 write port; legal range 1..16

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset (asynchronous, active-low)
start_i  input  1  start request; sampled only in IDLE
len_i  input  ADDR_WIDTH+1  element count 0..2^ADDR_WIDTH; latched on start acceptance
busy_o  output  1  high in RUN, DRAIN and DONE
done_o  output  1  one-cycle completion pulse
bram0_en_o  output  1  BRAM0 read enable
bram0_r_addr_o  output  ADDR_WIDTH  BRAM0 read address
bram1_web_o  output  1  BRAM1 write enable, active-high
bram1_w_addr_o  output  ADDR_WIDTH  BRAM1 write address

Behaviour:
- Reset: all outputs 0; state IDLE; element counter, drain counter and delay line cleared.
- Reset mid-operation aborts immediately. No further writes occur, and done_o is not asserted.
- States: IDLE, RUN, DRAIN, DONE. All state and outputs are registered.
- IDLE: start_i=1 at edge T latches len_i. The block moves to RUN if len>0, or to DONE if len=0.
- RUN: in cycle T+1+k (k=0..len-1), bram0_en_o=1 and bram0_r_addr_o=k.
- RUN exit: after issue k=len-1 the block goes to DRAIN, with bram0_en_o=0 and bram0_r_addr_o=0.
- DRAIN: lasts exactly LAT cycles, counted by the drain counter, then goes to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Write alignment: in every cycle c, bram1_web_o and bram1_w_addr_o equal the issue enable and address of cycle c-LAT. The write for element k is in cycle T+1+k+LAT.
- Final write: occurs in the last DRAIN cycle; done_o follows in the next cycle, T+len+LAT+1.
- Idle write port: when bram1_web_o=0, bram1_w_addr_o=0.
- len=2^ADDR_WIDTH: addresses 0..2^ADDR_WIDTH-1 with no wrap. The counter is ADDR_WIDTH+1 bits wide, so the terminal compare is exact.
- len values above 2^ADDR_WIDTH are clamped to 2^ADDR_WIDTH.
- start_i outside IDLE, including the DONE cycle, is ignored; len_i is not re-latched. A start held high through DONE is accepted in the following IDLE cycle.

Optional Feature:
Macro DSP_SEQ_PERF_CNT_EN.
- Defined: adds output cycles_o [15:0], reset 0.
  - Cleared on start acceptance, then counts every cycle spent in RUN, DRAIN and DONE.
  - Holds its value in IDLE until the next start; saturates at 16'hFFFF.
  - Expected values: len+LAT+1 for len>0, and 1 for len=0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared def.v: ADDR_WIDTH, LAT default, state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3), perf counter width.
- Sub-module delay_line, parameterised by WIDTH and DEPTH: async-reset shift register carrying {web, addr} through LAT stages. The controller instantiates one with WIDTH=ADDR_WIDTH+1 and DEPTH=LAT.

Test Plan:
- len=32, LAT=4, start at edge T:
  - bram0 addr 0..31 in cycles T+1..T+32.
  - bram1_web_o=1 with addr 0..31 in T+5..T+36.
  - done_o pulse at T+37; 32 writes total.
- len=1: single read addr 0 at T+1; single write addr 0 at T+5; done_o at T+6; busy_o high T+1..T+6.
- len=0: no bram0_en_o or bram1_web_o; busy_o and done_o high at T+1 only.
- start_i pulses during RUN and in the DONE cycle with a different len_i: ignored. Only the original burst occurs, with no second done_o.
- rst_ni low for 1 cycle during RUN at element 10:
  - All outputs 0 immediately, with no writes after release.
  - A new start with len=3 then behaves as in a fresh run.
- With DSP_SEQ_PERF_CNT_EN, LAT=4:
  - len=8 gives cycles_o=13, held in IDLE.
  - A following len=0 run gives cycles_o=1.

Source files
------------

// File: rtl/dsp_seq_ctrl_pkg.sv
// Shared definitions for the BRAM0 -> DSP -> BRAM1 sequencer.
// Holds the default address width and datapath latency, the FSM state encoding
// and the width of the optional cycle counter (macro DSP_SEQ_PERF_CNT_EN).
package dsp_seq_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int LAT_DEF        = 4;
  localparam int PERF_W         = 16;
  localparam int DRAIN_W        = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dsp_seq_ctrl_delay_line.sv
// delay_line: async-reset shift register, DEPTH stages of WIDTH bits.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, clears every stage
//   din    - value entering stage 0
//   dout   - value that entered DEPTH cycles earlier
module delay_line #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/dsp_seq_ctrl.sv
// dsp_seq_ctrl: burst sequencer for the BRAM0 -> DSP -> BRAM1 datapath.
// Accepts a start in IDLE, issues len consecutive BRAM0 reads, drains the
// LAT-cycle pipeline while the matching BRAM1 writes emerge from a delay line,
// then pulses done for one cycle.
// Ports:
//   clk_i, rst_ni           - clock, asynchronous active-low reset
//   start_i, len_i          - start request and element count (clamped to 2^ADDR_WIDTH)
//   busy_o, done_o          - busy in RUN/DRAIN/DONE, one-cycle completion pulse
//   bram0_en_o/r_addr_o     - BRAM0 read issue
//   bram1_web_o/w_addr_o    - BRAM1 write, read issue delayed by LAT cycles
//   cycles_o                - only with DSP_SEQ_PERF_CNT_EN: cycles of the last run
module dsp_seq_ctrl
  import dsp_seq_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LAT        = LAT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  bram0_en_o,
  output logic [ADDR_WIDTH-1:0] bram0_r_addr_o,
  output logic                  bram1_web_o,
  output logic [ADDR_WIDTH-1:0] bram1_w_addr_o
`ifdef DSP_SEQ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     cycles_o
`endif
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [DRAIN_W-1:0]  DRAIN_INIT = DRAIN_W'(LAT - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH:0]   wr_bus;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // cnt holds the index of the next read to issue; the burst ends when it
  // equals len, which is exact because cnt is one bit wider than the address.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    en_d    = 1'b0;
    addr_d  = '0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d = (len_i > MAX_LEN) ? MAX_LEN : len_i;
          if (len_d == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            en_d    = 1'b1;
            cnt_d   = (ADDR_WIDTH+1)'(1);
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == len_q) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          en_d   = 1'b1;
          addr_d = cnt_q[ADDR_WIDTH-1:0];
          cnt_d  = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign bram0_en_o     = en_q;
  assign bram0_r_addr_o = addr_q;

  // The read address is forced to zero whenever no read is issued, so the
  // delayed write address is zero whenever the write enable is low.
  delay_line #(
    .WIDTH(ADDR_WIDTH + 1),
    .DEPTH(LAT)
  ) u_delay (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .din   ({en_q, addr_q}),
    .dout  (wr_bus)
  );

  assign bram1_web_o    = wr_bus[ADDR_WIDTH];
  assign bram1_w_addr_o = wr_bus[ADDR_WIDTH-1:0];

`ifdef DSP_SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] cycles_q;

  // Cleared on start acceptance; counts every non-IDLE cycle and holds in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      cycles_q <= '0;
    end else if (state_q != ST_IDLE && cycles_q != {PERF_W{1'b1}}) begin
      cycles_q <= cycles_q + 1'b1;
    end
  end

  assign cycles_o = cycles_q;
`else
  // No cycle counter in this build.
`endif

endmodule

// File: tb/tb_dsp_seq_ctrl.sv
// Self-checking bench for dsp_seq_ctrl (ADDR_WIDTH=5, LAT=4).
// Expected reads, writes and done pulses are queued with their cycle numbers
// when a start is driven; a negedge monitor pops and compares them.
module tb_dsp_seq_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 4;

  typedef struct {
    int cyc;
    int addr;
  } ev_t;

  logic          clk_i   = 1'b0;
  logic          rst_ni  = 1'b1;
  logic          start_i = 1'b0;
  logic [AW:0]   len_i   = '0;
  logic          busy_o;
  logic          done_o;
  logic          bram0_en_o;
  logic [AW-1:0] bram0_r_addr_o;
  logic          bram1_web_o;
  logic [AW-1:0] bram1_w_addr_o;
`ifdef DSP_SEQ_PERF_CNT_EN
  logic [15:0]   cycles_o;
`endif

  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   busy_lo = -1;
  int   busy_hi = -2;
  ev_t  rd_q[$];
  ev_t  wr_q[$];
  int   done_q[$];

  dsp_seq_ctrl #(
    .ADDR_WIDTH(AW),
    .LAT       (LAT)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .len_i         (len_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .bram0_en_o    (bram0_en_o),
    .bram0_r_addr_o(bram0_r_addr_o),
    .bram1_web_o   (bram1_web_o),
    .bram1_w_addr_o(bram1_w_addr_o)
`ifdef DSP_SEQ_PERF_CNT_EN
    ,
    .cycles_o      (cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one start; returns the cycle in which the first read is visible.
  task automatic applyStimulus(input int len, output int e);
    int eff;
    @(negedge clk_i);
    #1;
    start_i = 1'b1;
    len_i   = (AW+1)'(len);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    e   = cyc;
    eff = (len > 32) ? 32 : len;
    for (int k = 0; k < eff; k++) begin
      rd_q.push_back('{cyc: e + k, addr: k});
      wr_q.push_back('{cyc: e + k + LAT, addr: k});
    end
    if (eff == 0) begin
      done_q.push_back(e);
      busy_lo = e;
      busy_hi = e;
    end else begin
      done_q.push_back(e + eff + LAT);
      busy_lo = e;
      busy_hi = e + eff + LAT;
    end
  endtask

  task automatic waitRun(input string tag);
    int n = 0;
    while (done_q.size() > 0 && n < 300) begin
      @(posedge clk_i);
      n++;
    end
    checkOutput({tag, "_done_pending"}, done_q.size(), 0);
    checkOutput({tag, "_rd_left"}, rd_q.size(), 0);
    checkOutput({tag, "_wr_left"}, wr_q.size(), 0);
    repeat (3) @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    ev_t ev;
    int  d;
    if (rst_ni) begin
      checkOutput("busy", int'(busy_o), int'(cyc >= busy_lo && cyc <= busy_hi));
      if (bram0_en_o) begin
        if (rd_q.size() == 0) begin
          checkOutput("rd_spurious", int'(bram0_en_o), 0);
        end else begin
          ev = rd_q.pop_front();
          checkOutput("rd_cycle", cyc, ev.cyc);
          checkOutput("rd_addr", int'(bram0_r_addr_o), ev.addr);
        end
      end else begin
        checkOutput("rd_addr_idle", int'(bram0_r_addr_o), 0);
      end
      if (bram1_web_o) begin
        if (wr_q.size() == 0) begin
          checkOutput("wr_spurious", int'(bram1_web_o), 0);
        end else begin
          ev = wr_q.pop_front();
          checkOutput("wr_cycle", cyc, ev.cyc);
          checkOutput("wr_addr", int'(bram1_w_addr_o), ev.addr);
        end
      end else begin
        checkOutput("wr_addr_idle", int'(bram1_w_addr_o), 0);
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          checkOutput("done_spurious", int'(done_o), 0);
        end else begin
          d = done_q.pop_front();
          checkOutput("done_cycle", cyc, d);
        end
      end
    end
  end

  initial begin
    int e;
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("rst_busy", int'(busy_o), 0);
    checkOutput("rst_done", int'(done_o), 0);
    checkOutput("rst_rd_en", int'(bram0_en_o), 0);
    checkOutput("rst_wr_en", int'(bram1_web_o), 0);
    checkOutput("rst_rd_addr", int'(bram0_r_addr_o), 0);
`ifdef DSP_SEQ_PERF_CNT_EN
    checkOutput("rst_cycles", int'(cycles_o), 0);
`endif
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("[TB] full burst len=32");
    applyStimulus(32, e);
    waitRun("len32");

    $display("[TB] single element");
    applyStimulus(1, e);
    waitRun("len1");

    $display("[TB] empty run");
    applyStimulus(0, e);
    waitRun("len0");

    $display("[TB] oversize length clamps to 32");
    applyStimulus(45, e);
    waitRun("len45");

    $display("[TB] starts during RUN and DONE are ignored");
    applyStimulus(5, e);
    while (cyc < e + 2) @(negedge clk_i);
    #1;
    start_i = 1'b1;
    len_i   = 6'd7;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    while (cyc < e + 5 + LAT) @(negedge clk_i);
    #1;
    start_i = 1'b1;
    len_i   = 6'd2;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (12) @(negedge clk_i);
    checkOutput("ign_done_pending", done_q.size(), 0);
    checkOutput("ign_rd_left", rd_q.size(), 0);
    checkOutput("ign_wr_left", wr_q.size(), 0);

    $display("[TB] reset during RUN at element 10");
    applyStimulus(32, e);
    while (cyc < e + 10) @(negedge clk_i);
    #1;
    rst_ni = 1'b0;
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    busy_lo = -1;
    busy_hi = -2;
    #1;
    checkOutput("abort_busy", int'(busy_o), 0);
    checkOutput("abort_rd_en", int'(bram0_en_o), 0);
    checkOutput("abort_rd_addr", int'(bram0_r_addr_o), 0);
    checkOutput("abort_wr_en", int'(bram1_web_o), 0);
    checkOutput("abort_wr_addr", int'(bram1_w_addr_o), 0);
    checkOutput("abort_done", int'(done_o), 0);
    @(posedge clk_i);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    applyStimulus(3, e);
    waitRun("post_reset_len3");

    $display("[TB] cycle counter runs");
    applyStimulus(8, e);
    waitRun("len8");
    repeat (4) @(negedge clk_i);
`ifdef DSP_SEQ_PERF_CNT_EN
    checkOutput("cycles_len8", int'(cycles_o), 8 + LAT + 1);
`endif
    applyStimulus(0, e);
    waitRun("len0b");
`ifdef DSP_SEQ_PERF_CNT_EN
    checkOutput("cycles_len0", int'(cycles_o), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
